// File: rtl/stump_uart_tx.sv
// rtl/stump_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the Stump bus
// Optional registered interrupt output: define STUMP_UART_IRQ_EN.
module stump_uart_tx #(
   parameter logic [15:0] BASE_ADDR    = 16'hFF00,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   input  logic [15:0] wr_data,
   input  logic        mem_wen,
   input  logic        mem_ren,
   output logic        hit,
   output logic [15:0] rd_data,
   output logic        txd,
   output logic        irq
);

   localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0]  DEPTH_C  = 5'(FIFO_DEPTH);
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // Decode by subtraction so BASE_ADDR need not be 4-aligned
   logic [15:0] offset;
   logic [1:0]  reg_sel;
   logic        wr_en;
   logic        push_req;
   logic        status_wr;
   logic        ctrl_wr;

   assign offset    = address - BASE_ADDR;
   assign hit       = (offset[15:2] == 14'd0);
   assign reg_sel   = offset[1:0];
   assign wr_en     = hit & mem_wen;
   assign push_req  = wr_en & (reg_sel == OFF_TXDATA);
   assign status_wr = wr_en & (reg_sel == OFF_STATUS);
   assign ctrl_wr   = wr_en & (reg_sel == OFF_CTRL);

   state_t           state_q;
   logic [15:0]      cyc_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             txd_q;

   logic [7:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             enable_q, enable_d;
   logic             irq_en_rd;

   logic full;
   logic empty;
   logic busy;
   logic pop;
   logic push_ok;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == 5'd0);
   assign busy    = (state_q != S_IDLE);
   assign pop     = (state_q == S_IDLE) & enable_q & ~empty;
   // A full FIFO still accepts a byte when the head leaves on the same edge
   assign push_ok = push_req & (~full | pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      enable_d   = enable_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
      if (push_req & ~push_ok) begin
         overflow_d = 1'b1;
      end else if (status_wr & wr_data[3]) begin
         overflow_d = 1'b0;
      end
      if (ctrl_wr) begin
         enable_d = wr_data[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= 5'd0;
         overflow_q <= 1'b0;
         enable_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem_q[wr_ptr_q] <= wr_data[7:0];
      end
   end

   // txd is registered from the current state, so the line lags the FSM by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cyc_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q <= fifo_mem_q[rd_ptr_q];
                  cyc_q   <= 16'd0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               txd_q <= 1'b0;
               if (cyc_q == BIT_LAST) begin
                  cyc_q   <= 16'd0;
                  bit_q   <= 3'd0;
                  state_q <= S_DATA;
               end else begin
                  cyc_q <= cyc_q + 16'd1;
               end
            end
            S_DATA: begin
               txd_q <= shift_q[0];
               if (cyc_q == BIT_LAST) begin
                  cyc_q   <= 16'd0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end else begin
                  cyc_q <= cyc_q + 16'd1;
               end
            end
            S_STOP: begin
               txd_q <= 1'b1;
               if (cyc_q == BIT_LAST) begin
                  cyc_q   <= 16'd0;
                  state_q <= S_IDLE;
               end else begin
                  cyc_q <= cyc_q + 16'd1;
               end
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign txd = txd_q;

`ifdef STUMP_UART_IRQ_EN
   logic irq_en_q;
   logic irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            irq_en_q <= wr_data[1];
         end
         irq_q <= irq_en_q & empty & ~busy;
      end
   end

   assign irq       = irq_q;
   assign irq_en_rd = irq_en_q;
`else
   assign irq       = 1'b0;
   assign irq_en_rd = 1'b0;
`endif

   always_comb begin
      rd_data = 16'h0000;
      if (hit & mem_ren) begin
         case (reg_sel)
            OFF_STATUS: rd_data = {7'd0, count_q, overflow_q, busy, empty, full};
            OFF_CTRL:   rd_data = {14'd0, irq_en_rd, enable_q};
            default:    rd_data = 16'h0000;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, wr_data[15:8]};

endmodule
